// File: rtl/cla_16_c_pkg.sv
// Shared constants for the 16-bit two-level carry-lookahead adder.
package cla_16_c_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned SLICE = 4;

endpackage

// File: rtl/cla_16_c_cla4.sv
// 4-bit carry-lookahead slice: local carries from its own p/g and carry-in,
// plus group propagate/generate for the second-level lookahead unit.
module cla_4bit
    import cla_16_c_pkg::*;
(
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    input  logic             i_cin,
    output logic [SLICE-1:0] o_sum,
    output logic             o_pg,
    output logic             o_gg
);

    logic [SLICE-1:0] w_p;
    logic [SLICE-1:0] w_g;
    logic [SLICE-1:0] w_c;

    // Per-bit terms, lookahead carries, sum bits and group terms
    always_comb begin
        w_g = i_a & i_b;
        w_p = i_a ^ i_b;

        w_c[0] = i_cin;
        w_c[1] = w_g[0] | (w_p[0] & i_cin);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & i_cin);

        o_sum = w_p ^ w_c;

        o_pg = &w_p;
        o_gg = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    end

endmodule

// File: rtl/cla_16_c.sv
// 16-bit adder built from four 4-bit lookahead slices and a second-level
// lookahead unit; only sum and cout are registered.
module cla_16_c
    import cla_16_c_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NSLICE = WIDTH / SLICE;

    logic [NSLICE-1:0] w_pg;
    logic [NSLICE-1:0] w_gg;
    logic [NSLICE:0]   w_c;      // w_c[k] is carry into slice k; w_c[NSLICE] is C16
    logic [WIDTH-1:0]  w_sum;

    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_slice
            cla_4bit u_slice (
                .i_a   (a[gi*SLICE +: SLICE]),
                .i_b   (b[gi*SLICE +: SLICE]),
                .i_cin (w_c[gi]),
                .o_sum (w_sum[gi*SLICE +: SLICE]),
                .o_pg  (w_pg[gi]),
                .o_gg  (w_gg[gi])
            );
        end
    endgenerate

    // Second-level lookahead: slice carry-ins straight from group PG/GG and cin
    always_comb begin
        w_c[0] = cin;
        w_c[1] = w_gg[0] | (w_pg[0] & cin);
        w_c[2] = w_gg[1] | (w_pg[1] & w_gg[0]) | (w_pg[1] & w_pg[0] & cin);
        w_c[3] = w_gg[2] | (w_pg[2] & w_gg[1]) | (w_pg[2] & w_pg[1] & w_gg[0])
               | (w_pg[2] & w_pg[1] & w_pg[0] & cin);
        w_c[4] = w_gg[3] | (w_pg[3] & w_gg[2]) | (w_pg[3] & w_pg[2] & w_gg[1])
               | (w_pg[3] & w_pg[2] & w_pg[1] & w_gg[0])
               | (w_pg[3] & w_pg[2] & w_pg[1] & w_pg[0] & cin);
    end

    // Output register; asynchronous reset clears any in-flight result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_c[NSLICE];
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_cla_16_c.sv
// Self-checking bench for cla_16_c: directed vectors, back-to-back timing,
// random vectors against a+b+cin, and asynchronous reset behaviour.
module tb_cla_16_c;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;

    int checks;
    int failures;

    cla_16_c dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [16:0] exp;
    } vec_t;

    task automatic test_reset();
        rst_n = 1'b0;
        a = 16'h1234; b = 16'h4321; cin = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cout, sum} !== 17'h0) begin
            failures++;
            $display("FAIL reset_hold: got cout=%b sum=%h, want cout=0 sum=0000", cout, sum);
        end
        // release with REQ-026 vector applied; first edge loads it
        a = 16'h0000; b = 16'h0000; cin = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({cout, sum} !== 17'h0) begin
            failures++;
            $display("FAIL zero_add: got cout=%b sum=%h, want cout=0 sum=0000", cout, sum);
        end
        // first loaded result must be the current inputs, not stale ones
        a = 16'h0001; b = 16'h0001; cin = 1'b1;
        @(negedge clk);
        checks++;
        if ({cout, sum} !== 17'h00003) begin
            failures++;
            $display("FAIL one_one_cin: got cout=%b sum=%h, want cout=0 sum=0003", cout, sum);
        end
    endtask

    task automatic test_directed();
        vec_t v [8];
        v[0] = '{16'hFFF6, 16'hFFFC, 1'b1, 17'h1FFF3};
        v[1] = '{16'hFFF6, 16'hFFF1, 1'b1, 17'h1FFE8};
        v[2] = '{16'h7FFE, 16'h7FF1, 1'b1, 17'h0FFF0};
        v[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
        v[4] = '{16'h8000, 16'h8000, 1'b0, 17'h10000};
        v[5] = '{16'h000F, 16'h0001, 1'b0, 17'h00010};
        v[6] = '{16'h0FFF, 16'h0000, 1'b1, 17'h01000};
        v[7] = '{16'hFFFF, 16'h0000, 1'b1, 17'h10000};
        for (int i = 0; i < 8; i++) begin
            a = v[i].a; b = v[i].b; cin = v[i].cin;
            @(negedge clk);
            checks++;
            if ({cout, sum} !== v[i].exp) begin
                failures++;
                $display("FAIL directed_%0d: got cout=%b sum=%h, want cout=%b sum=%h",
                         i, cout, sum, v[i].exp[16], v[i].exp[15:0]);
            end
        end
    endtask

    task automatic test_hold_between_edges();
        a = 16'h1111; b = 16'h2222; cin = 1'b0;
        @(negedge clk);
        // change inputs mid-cycle; registered outputs must not move
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
        #2;
        checks++;
        if ({cout, sum} !== 17'h03333) begin
            failures++;
            $display("FAIL input_isolation: got cout=%b sum=%h, want cout=0 sum=3333", cout, sum);
        end
        @(negedge clk);
        checks++;
        if ({cout, sum} !== 17'h1FFFF) begin
            failures++;
            $display("FAIL next_edge_load: got cout=%b sum=%h, want cout=1 sum=FFFF", cout, sum);
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] prev;
        vec_t v [4];
        v[0] = '{16'h0001, 16'h0002, 1'b0, 17'h00003};
        v[1] = '{16'hABCD, 16'h1234, 1'b1, 17'h0BE02};
        v[2] = '{16'hF000, 16'h1000, 1'b0, 17'h10000};
        v[3] = '{16'h00FF, 16'h00FF, 1'b1, 17'h001FF};
        a = v[0].a; b = v[0].b; cin = v[0].cin;
        prev = v[0].exp;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({cout, sum} !== prev) begin
                failures++;
                $display("FAIL b2b_%0d: got cout=%b sum=%h, want cout=%b sum=%h",
                         i - 1, cout, sum, prev[16], prev[15:0]);
            end
            a = v[i].a; b = v[i].b; cin = v[i].cin;
            prev = v[i].exp;
        end
        @(negedge clk);
        checks++;
        if ({cout, sum} !== prev) begin
            failures++;
            $display("FAIL b2b_3: got cout=%b sum=%h, want cout=%b sum=%h",
                     cout, sum, prev[16], prev[15:0]);
        end
    endtask

    task automatic test_random();
        logic [16:0] prev;
        int          rfail;
        rfail = 0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        prev = {1'b0, a} + {1'b0, b} + {16'h0, cin};
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            checks++;
            if ({cout, sum} !== prev) begin
                failures++;
                rfail++;
                if (rfail <= 10)
                    $display("FAIL random_%0d: got cout=%b sum=%h, want cout=%b sum=%h",
                             i, cout, sum, prev[16], prev[15:0]);
            end
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            prev = {1'b0, a} + {1'b0, b} + {16'h0, cin};
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
        @(negedge clk);
        checks++;
        if ({cout, sum} !== 17'h1FFFF) begin
            failures++;
            $display("FAIL pre_reset: got cout=%b sum=%h, want cout=1 sum=FFFF", cout, sum);
        end
        // assert reset between edges; outputs clear without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cout, sum} !== 17'h0) begin
            failures++;
            $display("FAIL async_clear: got cout=%b sum=%h, want cout=0 sum=0000", cout, sum);
        end
        // clocks during reset must not load anything
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({cout, sum} !== 17'h0) begin
            failures++;
            $display("FAIL reset_clocked: got cout=%b sum=%h, want cout=0 sum=0000", cout, sum);
        end
        a = 16'h1234; b = 16'h0F0F; cin = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({cout, sum} !== 17'h0) begin
            failures++;
            $display("FAIL release_no_edge: got cout=%b sum=%h, want cout=0 sum=0000", cout, sum);
        end
        @(negedge clk);
        checks++;
        if ({cout, sum} !== 17'h02143) begin
            failures++;
            $display("FAIL release_load: got cout=%b sum=%h, want cout=0 sum=2143", cout, sum);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        #1;
        checks++;
        if ({cout, sum} !== 17'h0) begin
            failures++;
            $display("FAIL reset_initial: got cout=%b sum=%h, want cout=0 sum=0000", cout, sum);
        end
        test_reset();
        test_directed();
        test_hold_between_edges();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
